// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receive-state encoding and 8N1 frame constants
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  localparam int CLKS_PER_BIT_DEF = 434;
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART byte receiver with 2-FF synchronizer and one-cycle valid/frame-error pulses
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       rx,
  input  logic       en,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_ferr,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  rx_state_t state_q, state_d;
  logic sync_q, rx_s_q;
  logic [CW-1:0] baud_q, baud_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic busy_q, busy_d;
  always_ff @(posedge CLK) begin
    if (rst) begin
      sync_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= rx;
      rx_s_q  <= sync_q;
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      busy_q  <= busy_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    busy_d   = busy_q;
    rx_valid = 1'b0;
    rx_ferr  = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!rx_s_q && en) begin
          state_d = START;
          busy_d  = 1'b1;
        end
      end
      START: if (baud_q == HALF) begin
        baud_d  = '0;
        bit_d   = '0;
        state_d = rx_s_q ? IDLE : DATA;
        busy_d  = !rx_s_q;
      end
      DATA: if (baud_q == FULL) begin
        baud_d  = '0;
        shift_d = {rx_s_q, shift_q[7:1]};
        bit_d   = bit_q + 1'b1;
        state_d = (bit_q == BW'(DATA_BITS - 1)) ? STOP : DATA;
      end
      STOP: if (baud_q == FULL) begin
        baud_d   = '0;
        state_d  = IDLE;
        busy_d   = 1'b0;
        rx_valid = rx_s_q;
        rx_ferr  = !rx_s_q;
      end
      default: state_d = IDLE;
    endcase
  end
  assign rx_byte = shift_q;
  assign busy    = busy_q;
endmodule

// File: rtl/uart_memloader.sv
// uart_memloader: fills a word-addressed memory from a UART byte stream, little-endian 32-bit words
module uart_memloader
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int ADDR_W       = 10,
  parameter int NUM_WORDS    = 1024
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              RX,
  output logic [ADDR_W-1:0] con_addr,
  output logic [31:0]       con_wr_data,
  output logic              con_wr_en,
  output logic              busy,
  output logic              done,
  output logic              frame_err
);
  logic [7:0] rx_byte;
  logic rx_valid, rx_ferr, take, last;
  logic [1:0] bcnt_q, bcnt_d;
  logic [23:0] buf_q, buf_d;
  logic [ADDR_W:0] wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic wr_q, wr_d, done_q, done_d, ferr_q, ferr_d;
  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .CLK      (CLK),
    .rst      (rst),
    .rx       (RX),
    .en       (!done_q),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr),
    .busy     (busy)
  );
  always_ff @(posedge CLK) begin
    if (rst) begin
      bcnt_q <= '0;
      buf_q  <= '0;
      wcnt_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      wr_q   <= 1'b0;
      done_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      bcnt_q <= bcnt_d;
      buf_q  <= buf_d;
      wcnt_q <= wcnt_d;
      addr_q <= addr_d;
      data_q <= data_d;
      wr_q   <= wr_d;
      done_q <= done_d;
      ferr_q <= ferr_d;
    end
  end
  always_comb begin
    take   = rx_valid && !done_q;
    last   = take && (bcnt_q == 2'd3);
    bcnt_d = take ? bcnt_q + 1'b1 : bcnt_q;
    buf_d  = buf_q;
    if (take && !last) buf_d[{bcnt_q, 3'b000} +: 8] = rx_byte;
    addr_d = last ? wcnt_q[ADDR_W-1:0] : addr_q;
    data_d = last ? {rx_byte, buf_q} : data_q;
    wr_d   = last;
    wcnt_d = wr_q ? wcnt_q + 1'b1 : wcnt_q;
    done_d = done_q | (wr_q && (wcnt_q == (ADDR_W + 1)'(NUM_WORDS - 1)));
    ferr_d = ferr_q | rx_ferr;
  end
  assign con_addr    = addr_q;
  assign con_wr_data = data_q;
  assign con_wr_en   = wr_q;
  assign done        = done_q;
  assign frame_err   = ferr_q;
endmodule

// File: tb/tb_uart_memloader.sv
// tb_uart_memloader: scoreboard bench for uart_memloader at 8 and 4 clocks per bit
module tb_uart_memloader;
  logic clk = 1'b0, rst = 1'b1, rx0 = 1'b1, rx1 = 1'b1;
  logic [1:0] a0, a1;
  logic [31:0] d0, d1;
  logic we0, we1, busy0, busy1, done0, done1, ferr0, ferr1;
  int n_cmp = 0, n_err = 0, busy_cnt0 = 0, b;
  logic [33:0] exp0[$], exp1[$];
  always #5 clk = ~clk;
  uart_memloader #(.CLKS_PER_BIT(8), .ADDR_W(2), .NUM_WORDS(4)) dut0 (
    .CLK(clk), .rst(rst), .RX(rx0), .con_addr(a0), .con_wr_data(d0), .con_wr_en(we0),
    .busy(busy0), .done(done0), .frame_err(ferr0));
  uart_memloader #(.CLKS_PER_BIT(4), .ADDR_W(2), .NUM_WORDS(4)) dut1 (
    .CLK(clk), .rst(rst), .RX(rx1), .con_addr(a1), .con_wr_data(d1), .con_wr_en(we1),
    .busy(busy1), .done(done1), .frame_err(ferr1));
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic send(input bit d, input logic [7:0] v, input logic stop);
    logic [9:0] f;
    f = {stop, v, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (d) rx1 = f[i]; else rx0 = f[i];
      repeat (d ? 4 : 8) @(negedge clk);
    end
    if (d) rx1 = 1'b1; else rx0 = 1'b1;
  endtask
  task automatic send0(input logic [7:0] v);
    send(1'b0, v, 1'b1);
    repeat (8) @(negedge clk);
  endtask
  task automatic wait_empty(input bit d, input string name);
    for (int i = 0; i < 400 && (d ? exp1.size() : exp0.size()) != 0; i++) @(negedge clk);
    check(name, 32'(d ? exp1.size() : exp0.size()), 32'd0);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask
  always @(negedge clk) if (busy0) busy_cnt0++;
  logic pe0 = 1'b0, pe1 = 1'b0;
  logic [1:0] pa0 = '0;
  logic [33:0] e0, e1;
  always @(negedge clk) begin
    if (!rst) begin
      if (we0) begin
        if (exp0.size() == 0) check("wr0_unexpected", 32'(we0), 32'd0);
        else begin
          e0 = exp0.pop_front();
          check("wr0_addr", 32'(a0), 32'(e0[33:32]));
          check("wr0_data", d0, e0[31:0]);
        end
        check("wr0_done_early", 32'(done0), 32'd0);
      end
      if (pe0) begin
        check("wr0_width", 32'(we0), 32'd0);
        check("wr0_done_edge", 32'(done0), 32'(pa0 == 2'd3));
      end
    end
    pe0 = we0;
    pa0 = a0;
  end
  always @(negedge clk) begin
    if (!rst) begin
      if (we1) begin
        if (exp1.size() == 0) check("wr1_unexpected", 32'(we1), 32'd0);
        else begin
          e1 = exp1.pop_front();
          check("wr1_addr", 32'(a1), 32'(e1[33:32]));
          check("wr1_data", d1, e1[31:0]);
        end
      end
      if (pe1) check("wr1_width", 32'(we1), 32'd0);
    end
    pe1 = we1;
  end
  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_addr", 32'(a0), 32'd0);
    check("rst_data", d0, 32'd0);
    check("rst_wr_en", 32'(we0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_ferr", 32'(ferr0), 32'd0);
    exp0.push_back({2'd0, 32'hADE1B056});
    send0(8'h56); send0(8'hB0); send0(8'hE1); send0(8'hAD);
    wait_empty(1'b0, "t1_drain");
    check("t1_done", 32'(done0), 32'd0);
    do_reset();
    exp0.push_back({2'd0, 32'h03020100});
    exp0.push_back({2'd1, 32'h07060504});
    exp0.push_back({2'd2, 32'h0B0A0908});
    exp0.push_back({2'd3, 32'h0F0E0D0C});
    for (int i = 0; i < 16; i++) send0(8'(i));
    wait_empty(1'b0, "t2_drain");
    check("t2_done", 32'(done0), 32'd1);
    b = busy_cnt0;
    send0(8'hFF);
    repeat (20) @(negedge clk);
    check("t2_busy_after_done", 32'(busy_cnt0 - b), 32'd0);
    check("t2_done_sticky", 32'(done0), 32'd1);
    do_reset();
    b = busy_cnt0;
    rx0 = 1'b0;
    repeat (2) @(negedge clk);
    rx0 = 1'b1;
    repeat (20) @(negedge clk);
    check("t3_busy_pulse", 32'(busy_cnt0 > b), 32'd1);
    check("t3_busy_idle", 32'(busy0), 32'd0);
    check("t3_ferr", 32'(ferr0), 32'd0);
    exp0.push_back({2'd0, 32'h44332211});
    send0(8'h11); send0(8'h22); send0(8'h33); send0(8'h44);
    wait_empty(1'b0, "t3_drain");
    do_reset();
    send(1'b0, 8'h55, 1'b0);
    repeat (16) @(negedge clk);
    check("t4_ferr_set", 32'(ferr0), 32'd1);
    exp0.push_back({2'd0, 32'h22334455});
    send0(8'h55); send0(8'h44); send0(8'h33); send0(8'h22);
    wait_empty(1'b0, "t4_drain");
    check("t4_ferr_sticky", 32'(ferr0), 32'd1);
    send0(8'h12); send0(8'h34);
    do_reset();
    check("t5_addr", 32'(a0), 32'd0);
    check("t5_data", d0, 32'd0);
    check("t5_wr_en", 32'(we0), 32'd0);
    check("t5_busy", 32'(busy0), 32'd0);
    check("t5_done", 32'(done0), 32'd0);
    check("t5_ferr", 32'(ferr0), 32'd0);
    exp0.push_back({2'd0, 32'hDDCCBBAA});
    send0(8'hAA); send0(8'hBB); send0(8'hCC); send0(8'hDD);
    wait_empty(1'b0, "t5_drain");
    exp1.push_back({2'd0, 32'h04030201});
    exp1.push_back({2'd1, 32'h08070605});
    for (int i = 1; i <= 8; i++) send(1'b1, 8'(i), 1'b1);
    repeat (4) @(negedge clk);
    wait_empty(1'b1, "t6_drain");
    check("t6_ferr", 32'(ferr1), 32'd0);
    check("t6_done", 32'(done1), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_memloader.md
Name: uart_memloader

Overview:
- UART receiver that fills a word-addressed memory (data or instruction BRAM) from a serial byte stream.
- Inverse of the memory-dump path: bytes arrive on RX, are assembled little-endian into 32-bit words, and are written to sequential addresses through a single write port.
- Sits between the board RX pin and the memory's spare port; the core is held off until done rises.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200 baud); minimum 4.
- ADDR_W, 10, memory word-address width.
- NUM_WORDS, 1024, words to load before done; 1 to 2^ADDR_W.

Ports:
- CLK  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- RX  in  1  asynchronous serial input; idles high; 8N1, LSB first.
- con_addr  out  ADDR_W  memory word address for the current write.
- con_wr_data  out  32  word being written.
- con_wr_en  out  1  one-cycle write strobe.
- busy  out  1  high from a detected start bit until that frame's stop bit is sampled.
- done  out  1  sticky; high once NUM_WORDS words have been written.
- frame_err  out  1  sticky; set when any stop bit samples low.

Behaviour:
- Reset, sampled on the CLK edge while rst=1:
  - All outputs go to 0.
  - Internal state goes to IDLE.
  - Byte count, word count, bit count and baud counter clear.
  - Synchronizer flops preset to 1.
  - A reset mid-frame or mid-word discards all partial data.
- RX passes through a 2-FF synchronizer. All decisions use the synchronized value rx_s.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if rx_s=0 and done=0, go to START, clear the baud counter, assert busy. When done=1, RX is ignored permanently until reset.
  - START: wait CLKS_PER_BIT/2 cycles (integer division), then sample rx_s.
    - rx_s=0: go to DATA, bit count=0, baud counter=0.
    - rx_s=1: glitch; go to IDLE, deassert busy, no error.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into the shift register, LSB first. After the 8th sample, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - rx_s=1: byte valid.
    - rx_s=0: set frame_err and discard the byte; byte count is unchanged.
    - Either way, return to IDLE and deassert busy on the same edge. There is no wait for line idle; the next falling edge starts a new frame.
- Word assembly, little-endian:
  - Valid byte k (k=0..3) is written to bits [8k+7:8k] of the word buffer; byte count then increments.
  - On the 4th valid byte, in the cycle after the stop-bit sample:
    - con_wr_data = the assembled word.
    - con_addr = word count.
    - con_wr_en = 1 for exactly one cycle.
  - On the following edge, word count increments and byte count returns to 0.
  - con_addr holds its value between strobes.
- Completion:
  - When the write with con_addr = NUM_WORDS-1 issues, done rises on the same edge as the word count increments. It stays high until rst.
  - The word counter never wraps. Address sequence is 0..NUM_WORDS-1 exactly once.
- Latency:
  - Stop-bit sample to con_wr_en is 1 cycle.
  - Falling RX edge to busy is 3 cycles: 2 for the synchronizer plus 1 for the state register.
- frame_err does not block loading; subsequent valid bytes continue to fill the current word.

Decomposition:
- Shared package (uart_pkg) holds:
  - the rx state encoding (IDLE/START/DATA/STOP);
  - the default CLKS_PER_BIT constant;
  - UART frame constants: 8 data bits, 1 stop bit. These are shared with the dump transmitter.
- One sub-module: uart_rx_byte.
  - Contents: synchronizer, FSM, baud and bit counters.
  - Outputs: rx_byte[7:0], rx_valid (one-cycle pulse), rx_ferr (one-cycle pulse), busy.
- uart_memloader instantiates uart_rx_byte and adds the byte/word assembly, the address counter and done.

Test Plan:
- CLKS_PER_BIT=8, NUM_WORDS=4, ADDR_W=2. Send bytes 56 B0 E1 AD -> one con_wr_en pulse with con_addr=0, con_wr_data=32'hADE1B056; done stays 0.
- Send 16 bytes 00..0F -> writes at addresses 0..3 of 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C. done=1 on the same edge as the 4th strobe completes. A further byte FF produces no strobe and busy stays 0.
- Drive a 2-cycle low glitch on RX -> busy pulses, then returns to IDLE. No byte counted, no frame_err.
- Send byte 55 with the stop bit held low, then 55 44 33 22 -> frame_err=1 (sticky), first byte dropped, single write of 32'h22334455 at address 0.
- Assert rst for 1 cycle after 2 bytes of a word, then send AA BB CC DD -> all outputs 0 after reset, then write of 32'hDDCCBBAA at address 0.
- Send back-to-back frames with no idle gap between stop and next start at CLKS_PER_BIT=4 -> all bytes received, 1-cycle write strobes, no frame_err.
